// File: rtl/conv_mac_sequencer_if.sv
// Buffer, multiplier and accumulator bundle
// for one conv_mac_sequencer processing element.
interface conv_mac_sequencer_if #(
  parameter int ADDR_W = 4
);
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] buf_addr;
  logic [31:0]       win_data;
  logic [31:0]       ker_data;
  logic [31:0]       mult_a;
  logic [31:0]       mult_b;
  logic [31:0]       mult_result;
  logic              accum_clr;
  logic              accum_en;
  logic [31:0]       product;
  logic [ADDR_W:0]   tap_count;

  modport master (
    input  start, win_data, ker_data, mult_result,
    output busy, done, buf_addr, mult_a, mult_b,
    output accum_clr, accum_en, product, tap_count
  );

  modport slave (
    output start, win_data, ker_data, mult_result,
    input  busy, done, buf_addr, mult_a, mult_b,
    input  accum_clr, accum_en, product, tap_count
  );
endinterface

// File: rtl/conv_mac_sequencer.sv
// Walks one convolution window through the shared multiplier
// and drives the accumulator clear/enable strobes.
module conv_mac_sequencer #(
  parameter int N_TAPS = 9,
  parameter int ADDR_W = 4
) (
  input logic                  clk,
  input logic                  reset,
  conv_mac_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, CLR, RUN, DRAIN, DONE
  } state_t;

  localparam int unsigned LAST_I = N_TAPS - 1;
  localparam logic [ADDR_W:0] LAST = LAST_I[ADDR_W:0];

  state_t          state, state_n;
  // one extra bit so N_TAPS = 2**ADDR_W never wraps
  logic [ADDR_W:0] cnt;
  logic            drain_cnt;
  logic            v1;
  logic            en_q;
  logic [31:0]     prod_q;
  logic [ADDR_W:0] taps_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      drain_cnt <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= (state == RUN) ? cnt + 1'b1 : '0;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bus.start) state_n = CLR;
      CLR:     state_n = RUN;
      RUN:     if (cnt == LAST) state_n = DRAIN;
      DRAIN:   if (drain_cnt) state_n = DONE;
      DONE:    state_n = bus.start ? CLR : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1     <= 1'b0;
      en_q   <= 1'b0;
      prod_q <= '0;
      taps_q <= '0;
    end else begin
      v1   <= (state == RUN);
      en_q <= v1;
      if (v1) begin
        prod_q <= bus.mult_result;
        taps_q <= taps_q + 1'b1;
      end else if (state == CLR) begin
        taps_q <= '0;
      end
    end
  end

  always_comb begin
    bus.buf_addr  = '0;
    bus.mult_a    = '0;
    bus.mult_b    = '0;
    bus.accum_clr = (state == CLR);
    bus.busy      = (state == CLR) ||
                    (state == RUN) ||
                    (state == DRAIN);
    bus.done      = (state == DONE);
    if (state == RUN) bus.buf_addr = cnt[ADDR_W-1:0];
    if (v1) begin
      bus.mult_a = bus.win_data;
      bus.mult_b = bus.ker_data;
    end
  end

  assign bus.accum_en  = en_q;
  assign bus.product   = prod_q;
  assign bus.tap_count = taps_q;

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Directed bench: three sequencers (9, 1 and 16 taps)
// sharing clock, reset, start and buffer contents.
module tb_conv_mac_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  conv_mac_sequencer_if #(.ADDR_W(4)) ia ();
  conv_mac_sequencer_if #(.ADDR_W(4)) ib ();
  conv_mac_sequencer_if #(.ADDR_W(4)) ic ();

  conv_mac_sequencer #(.N_TAPS(9), .ADDR_W(4)) u_a (
    .clk(clk), .reset(reset), .bus(ia.master)
  );
  conv_mac_sequencer #(.N_TAPS(1), .ADDR_W(4)) u_b (
    .clk(clk), .reset(reset), .bus(ib.master)
  );
  conv_mac_sequencer #(.N_TAPS(16), .ADDR_W(4)) u_c (
    .clk(clk), .reset(reset), .bus(ic.master)
  );

  logic [31:0] wmem [16];
  logic [31:0] kmem [16];

  function automatic logic [31:0] fmul(
    input logic [31:0] a, input logic [31:0] b
  );
    if (a == 32'h3F80_0000 && b == 32'h4000_0000)
      return 32'h4000_0000;
    if (a == 32'hBFC0_0000 && b == 32'h4040_0000)
      return 32'hC090_0000;
    return a ^ b;
  endfunction

  assign ia.mult_result = fmul(ia.mult_a, ia.mult_b);
  assign ib.mult_result = fmul(ib.mult_a, ib.mult_b);
  assign ic.mult_result = fmul(ic.mult_a, ic.mult_b);

  always @(posedge clk) begin
    ia.win_data <= wmem[ia.buf_addr];
    ia.ker_data <= kmem[ia.buf_addr];
    ib.win_data <= wmem[ib.buf_addr];
    ib.ker_data <= kmem[ib.buf_addr];
    ic.win_data <= wmem[ic.buf_addr];
    ic.ker_data <= kmem[ic.buf_addr];
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(
    input string tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic set_start(input logic s);
    ia.start = s;
    ib.start = s;
    ic.start = s;
  endtask

  logic [63:0] clr_a, en_a, done_a, busy_a;
  logic [63:0] en_b, done_b, done_c;
  logic [31:0] prod_a [64];
  logic [31:0] ma_a [64];
  logic [31:0] mb_a [64];
  logic [4:0]  tc_a [64];
  logic [4:0]  tc_c [64];
  logic [3:0]  addr_a [64];
  logic [3:0]  addr_c [64];

  // start is sampled at edge 0; cycle c is recorded mid-cycle
  task automatic run(input int ncyc, input logic [63:0] smask);
    clr_a = '0; en_a = '0; done_a = '0; busy_a = '0;
    en_b = '0; done_b = '0; done_c = '0;
    @(negedge clk);
    set_start(1'b1);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      set_start(smask[c]);
      clr_a[c]  = ia.accum_clr;
      en_a[c]   = ia.accum_en;
      done_a[c] = ia.done;
      busy_a[c] = ia.busy;
      prod_a[c] = ia.product;
      ma_a[c]   = ia.mult_a;
      mb_a[c]   = ia.mult_b;
      tc_a[c]   = ia.tap_count;
      addr_a[c] = ia.buf_addr;
      en_b[c]   = ib.accum_en;
      done_b[c] = ib.done;
      done_c[c] = ic.done;
      addr_c[c] = ic.buf_addr;
      tc_c[c]   = ic.tap_count;
    end
    set_start(1'b0);
    repeat (3) @(negedge clk);
  endtask

  int errs;
  int amax;
  logic seen;
  logic [63:0] smask;

  initial begin
    set_start(1'b0);
    for (int i = 0; i < 16; i++) begin
      wmem[i] = 32'h3F80_0000;
      kmem[i] = 32'h4000_0000;
    end
    #1;
    chk("reset_ctl", {ia.busy, ia.done, ia.accum_clr,
      ia.accum_en, ia.buf_addr, ia.tap_count}, 64'd0);
    chk("reset_data", {ia.mult_a, ia.product}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // abort mid-RUN
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    repeat (4) @(negedge clk);
    chk("pre_abort_prod", ia.product, 64'h4000_0000);
    reset = 1'b1;
    #1;
    chk("abort_ctl", {ia.busy, ia.done, ia.accum_clr,
      ia.accum_en, ia.buf_addr, ia.tap_count}, 64'd0);
    chk("abort_data", {ia.mult_a, ia.product}, 64'd0);
    chk("abort_mb", ia.mult_b, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen |= ia.done;
    end
    chk("abort_no_done", seen, 64'd0);

    // single window, all taps 1.0 * 2.0
    run(24, 64'd0);
    chk("single_clr", clr_a, 64'h2);
    chk("single_en", en_a, 64'h1FF << 4);
    chk("single_done", done_a, 64'h1 << 13);
    chk("single_busy", busy_a, 64'h1FFE);
    chk("single_tc", tc_a[13], 64'd9);
    chk("single_ma3", ma_a[3], 64'h3F80_0000);
    chk("single_mb3", mb_a[3], 64'h4000_0000);
    errs = 0;
    for (int c = 4; c <= 12; c++)
      if (prod_a[c] !== 32'h4000_0000) errs++;
    chk("single_prod", errs, 64'd0);
    errs = 0;
    for (int c = 1; c <= 24; c++) begin
      if (c >= 2 && c <= 10) begin
        if (addr_a[c] !== 4'(c - 2)) errs++;
      end else if (addr_a[c] !== 4'd0) errs++;
    end
    chk("single_addr", errs, 64'd0);
    chk("idle_ma", ma_a[20], 64'd0);

    chk("n1_en", en_b, 64'h1 << 4);
    chk("n1_done", done_b, 64'h1 << 5);

    chk("n16_done", done_c, 64'h1 << 20);
    chk("n16_tc", tc_c[20], 64'd16);
    errs = 0;
    amax = 0;
    for (int c = 1; c <= 24; c++) begin
      if (int'(addr_c[c]) > amax) amax = int'(addr_c[c]);
      if (c >= 2 && c <= 17) begin
        if (addr_c[c] !== 4'(c - 2)) errs++;
      end else if (addr_c[c] !== 4'd0) errs++;
    end
    chk("n16_addr_seq", errs, 64'd0);
    chk("n16_addr_max", amax, 64'd15);

    // signed operands on tap 0
    wmem[0] = 32'hBFC0_0000;
    kmem[0] = 32'h4040_0000;
    run(16, 64'd0);
    chk("signed_ma", ma_a[3], 64'hBFC0_0000);
    chk("signed_mb", mb_a[3], 64'h4040_0000);
    chk("signed_prod", prod_a[4], 64'hC090_0000);
    wmem[0] = 32'h3F80_0000;
    kmem[0] = 32'h4000_0000;

    // start pulses while busy
    smask = (64'h1 << 2) | (64'h1 << 6) | (64'h1 << 11);
    run(24, smask);
    chk("ign_clr", clr_a, 64'h2);
    chk("ign_en", en_a, 64'h1FF << 4);
    chk("ign_done", done_a, 64'h1 << 13);

    // start held through DONE
    smask = ((64'h1 << 14) - 1) & ~64'h1;
    run(30, smask);
    chk("b2b_clr", clr_a, (64'h1 << 1) | (64'h1 << 14));
    chk("b2b_en", en_a, (64'h1FF << 4) | (64'h1FF << 17));
    chk("b2b_done", done_a, (64'h1 << 13) | (64'h1 << 26));
    chk("b2b_overlap", en_a & clr_a, 64'd0);
    chk("b2b_tc", tc_a[26], 64'd9);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
